// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with decode, iterative multiply/divide and HI/LO registers
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         alu_op,
  input  logic [5:0]         funct,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               illegal,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t state;
  logic [WIDTH-1:0] hi, lo, op_b, res_n, abs_a, abs_b, rnext, qfin, rfin;
  logic [2*WIDTH-1:0] prod, pnext, pfin, dnext;
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH:0] psum, rsh, rdiff;
  logic [5:0] fn;
  logic neg_q, neg_r, ill_n, is_mul, is_div, sgn, accept, last, ge;
  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  assign busy = state != IDLE;
  assign zero = result == '0;
  assign fn = alu_op == 2'b00 ? 6'b100000 : alu_op == 2'b01 ? 6'b100010 : alu_op == 2'b11 ? 6'b100100 : funct;
  assign is_mul = fn[5:1] == 5'b01100;
  assign is_div = fn[5:1] == 5'b01101;
  assign sgn = !fn[0];
  assign abs_a = sgn && src_a[WIDTH-1] ? -src_a : src_a;
  assign abs_b = sgn && src_b[WIDTH-1] ? -src_b : src_b;
  assign last = cnt == SHAMT_W'(WIDTH-1);
  // Shift-add step: upper half accumulates the multiplicand, the whole register shifts right
  assign psum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, op_b} : '0);
  assign pnext = {psum, prod[WIDTH-1:1]};
  assign pfin = neg_q ? -pnext : pnext;
  // Restoring step: upper half is the partial remainder, lower half shifts dividend out and quotient in
  assign rsh = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
  assign rdiff = rsh - {1'b0, op_b};
  assign ge = rsh >= {1'b0, op_b};
  assign rnext = ge ? rdiff[WIDTH-1:0] : rsh[WIDTH-1:0];
  assign dnext = {rnext, prod[WIDTH-2:0], ge};
  assign qfin = neg_q ? -dnext[WIDTH-1:0] : dnext[WIDTH-1:0];
  assign rfin = neg_r ? -dnext[2*WIDTH-1:WIDTH] : dnext[2*WIDTH-1:WIDTH];
  // Single-cycle result and illegal-funct decode
  always_comb begin
    res_n = '0;
    ill_n = 1'b0;
    case (fn)
      6'b100000: res_n = src_a + src_b;
      6'b100010: res_n = src_a - src_b;
      6'b100100: res_n = src_a & src_b;
      6'b100101: res_n = src_a | src_b;
      6'b100110: res_n = src_a ^ src_b;
      6'b100111: res_n = ~(src_a | src_b);
      6'b101010: res_n = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      6'b101011: res_n = {{(WIDTH-1){1'b0}}, src_a < src_b};
      6'b000000: res_n = src_a << shamt;
      6'b000010: res_n = src_a >> shamt;
      6'b000011: res_n = WIDTH'($signed(src_a) >>> shamt);
      6'b011000, 6'b011001, 6'b011010, 6'b011011: res_n = '0;
      6'b010000: res_n = hi;
      6'b010010: res_n = lo;
      default: ill_n = 1'b1;
    endcase
  end
  // Control FSM: accept, iterate multiply/divide, register results and HI/LO
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      out_valid <= 1'b0;
      result <= '0;
      illegal <= 1'b0;
      hi <= '0;
      lo <= '0;
      cnt <= '0;
      prod <= '0;
      op_b <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          prod <= {{WIDTH{1'b0}}, abs_a};
          op_b <= abs_b;
          neg_q <= sgn && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
          neg_r <= sgn && src_a[WIDTH-1];
          cnt <= '0;
          result <= res_n;
          illegal <= ill_n;
          if (is_mul) state <= MUL;
          else if (is_div && src_b != '0) state <= DIV;
          else begin
            out_valid <= 1'b1;
            if (is_div) begin
              lo <= '1;
              hi <= src_a;
            end
          end
        end
        MUL: begin
          prod <= pnext;
          cnt <= cnt + 1'b1;
          if (last) begin
            {hi, lo} <= pfin;
            out_valid <= 1'b1;
            state <= IDLE;
          end
        end
        DIV: begin
          prod <= dnext;
          cnt <= cnt + 1'b1;
          if (last) begin
            lo <= qfin;
            hi <= rfin;
            out_valid <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and randomized checks of alu_exec_unit against an arithmetic model
module tb_alu_exec_unit;
  localparam int W = 32;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, zero, illegal, busy;
  logic [1:0] alu_op = 0;
  logic [5:0] funct = 0;
  logic [31:0] src_a = 0, src_b = 0, result;
  logic [4:0] shamt = 0;
  int vectors = 0, miscompares = 0;
  logic [31:0] mhi = 0, mlo = 0;
  always #5 clk = ~clk;
  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op),
    .funct(funct), .src_a(src_a), .src_b(src_b), .shamt(shamt), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal), .busy(busy)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // Expected result, illegal flag and latency; updates the model HI/LO
  task automatic model(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, output logic [31:0] r, output logic il, output int lat);
    logic [5:0] f;
    longint p;
    logic [63:0] u;
    f = op == 2'b00 ? 6'h20 : op == 2'b01 ? 6'h22 : op == 2'b11 ? 6'h24 : fn;
    r = 0;
    il = 0;
    lat = 1;
    case (f)
      6'h20: r = a + b;
      6'h22: r = a - b;
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      6'h2a: r = (int'(a) < int'(b)) ? 1 : 0;
      6'h2b: r = (a < b) ? 1 : 0;
      6'h00: r = a << sh;
      6'h02: r = a >> sh;
      6'h03: r = int'(a) >>> sh;
      6'h18: begin p = longint'(int'(a)) * longint'(int'(b)); {mhi, mlo} = p; lat = W + 1; end
      6'h19: begin u = {32'b0, a} * {32'b0, b}; {mhi, mlo} = u; lat = W + 1; end
      6'h1a: if (b == 0) begin mlo = '1; mhi = a; end
             else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin mlo = a; mhi = 0; lat = W + 1; end
             else begin mlo = int'(a) / int'(b); mhi = int'(a) % int'(b); lat = W + 1; end
      6'h1b: if (b == 0) begin mlo = '1; mhi = a; end
             else begin mlo = a / b; mhi = a % b; lat = W + 1; end
      6'h10: r = mhi;
      6'h12: r = mlo;
      default: il = 1;
    endcase
  endtask
  task automatic run_op(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh);
    logic [31:0] er;
    logic ei;
    int lat, n;
    model(op, fn, a, b, sh, er, ei, lat);
    @(negedge clk);
    alu_op = op; funct = fn; src_a = a; src_b = b; shamt = sh; in_valid = 1; out_ready = 1;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk("in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 0; src_a = $urandom; src_b = $urandom; shamt = 5'($urandom); funct = 6'($urandom);
    chk("busy", busy, lat != 1);
    chk("ready_after_accept", in_ready, lat == 1);
    n = 1;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    chk("latency", n, lat);
    chk("result", result, er);
    chk("illegal", illegal, ei);
    chk("zero", zero, er == 0);
  endtask
  initial begin
    logic [5:0] codes [17] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03,
                               6'h18, 6'h19, 6'h1a, 6'h1b, 6'h10, 6'h12};
    logic [1:0] op;
    logic [5:0] fn;
    logic [31:0] a, b, exp_r;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 1);
    chk("rst_busy", busy, 0);
    chk("rst_illegal", illegal, 0);
    rst_n = 1;
    run_op(2'b10, 6'h10, 0, 0, 0);
    run_op(2'b10, 6'h12, 0, 0, 0);
    run_op(2'b00, 6'h00, 5, 7, 0);
    run_op(2'b10, 6'h2a, 32'hFFFFFFFF, 1, 0);
    run_op(2'b10, 6'h2b, 32'hFFFFFFFF, 1, 0);
    run_op(2'b10, 6'h03, 32'h80000000, 0, 4);
    run_op(2'b10, 6'h18, 32'hFFFFFFFD, 5, 0);
    run_op(2'b10, 6'h10, 0, 0, 0);
    run_op(2'b10, 6'h12, 0, 0, 0);
    run_op(2'b10, 6'h1a, 32'hFFFFFFF9, 2, 0);
    run_op(2'b10, 6'h12, 0, 0, 0);
    run_op(2'b10, 6'h10, 0, 0, 0);
    run_op(2'b10, 6'h1b, 9, 0, 0);
    run_op(2'b10, 6'h12, 0, 0, 0);
    run_op(2'b10, 6'h10, 0, 0, 0);
    run_op(2'b10, 6'h1a, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op(2'b10, 6'h12, 0, 0, 0);
    run_op(2'b10, 6'h10, 0, 0, 0);
    run_op(2'b10, 6'h3f, 3, 4, 0);
    @(negedge clk);
    out_ready = 0; in_valid = 1; alu_op = 2'b00; src_a = 1; src_b = 2;
    @(negedge clk);
    src_a = 100; src_b = 1;
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_result", result, 3);
      chk("hold_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1;
    exp_r = 101;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b2b_valid", out_valid, 1);
      chk("b2b_result", result, exp_r);
      src_a = 200 + i;
      exp_r = src_a + src_b;
    end
    in_valid = 0;
    @(negedge clk);
    for (int i = 0; i < 120; i++) begin
      op = 2'($urandom_range(0, 3));
      fn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : codes[$urandom_range(0, 16)];
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom;
      if ($urandom_range(0, 15) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      run_op(op, fn, a, b, 5'($urandom));
      if (op == 2'b10 && fn[5:2] == 4'b0110) begin
        run_op(2'b10, 6'h10, 0, 0, 0);
        run_op(2'b10, 6'h12, 0, 0, 0);
      end
    end
    run_op(2'b10, 6'h19, 3, 4, 0);
    @(negedge clk);
    alu_op = 2'b10; funct = 6'h19; src_a = 7; src_b = 9; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (10) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst_n = 0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_zero", zero, 1);
    mhi = 0;
    mlo = 0;
    @(negedge clk);
    rst_n = 1;
    run_op(2'b10, 6'h12, 0, 0, 0);
    run_op(2'b10, 6'h10, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
